operand_fetch: RTL

- Operand-fetch stage between decode and execute in the RV32I core.
- Reads rs1/rs2 from the register file's two combinational read ports.
- Bypasses same-cycle writeback data and tracks outstanding writes in a per-register scoreboard.
- Stalls on RAW/WAW hazards and presents operands through a one-entry valid/ready output register.

---
 rtl/operand_fetch.sv | 114 +++++++++++
 1 files changed

// File: rtl/operand_fetch.sv
// Operand-fetch stage: register-file read with writeback bypass, per-register
// pending scoreboard for RAW/WAW stalls, and a one-entry valid/ready output register.
module operand_fetch #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [ADDR_WIDTH-1:0] i_rs1,
    input  logic [ADDR_WIDTH-1:0] i_rs2,
    input  logic [ADDR_WIDTH-1:0] i_rd,
    input  logic                  i_rd_we,
    output logic [ADDR_WIDTH-1:0] o_rf_rd_addr_1,
    input  logic [DATA_WIDTH-1:0] i_rf_rd_data_1,
    output logic [ADDR_WIDTH-1:0] o_rf_rd_addr_2,
    input  logic [DATA_WIDTH-1:0] i_rf_rd_data_2,
    input  logic                  i_wb_we,
    input  logic [ADDR_WIDTH-1:0] i_wb_addr,
    input  logic [DATA_WIDTH-1:0] i_wb_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_rs1_data,
    output logic [DATA_WIDTH-1:0] o_rs2_data,
    output logic [ADDR_WIDTH-1:0] o_rd,
    output logic                  o_rd_we
);
    localparam int NREG = 1 << ADDR_WIDTH;

    typedef enum logic {EMPTY, FULL} state_e;

    state_e                state_q, state_d;
    logic [NREG-1:0]       pend_q, pend_d;
    logic [DATA_WIDTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                  rd_we_q, rd_we_d;
    logic                  hit_rs1, hit_rs2, hit_rd;
    logic                  hazard, accept;

    assign o_rf_rd_addr_1 = i_rs1;
    assign o_rf_rd_addr_2 = i_rs2;

    // A writeback landing this edge resolves the hazard it would otherwise cause.
    assign hit_rs1 = i_wb_we && (i_wb_addr == i_rs1) && (i_rs1 != '0);
    assign hit_rs2 = i_wb_we && (i_wb_addr == i_rs2) && (i_rs2 != '0);
    assign hit_rd  = i_wb_we && (i_wb_addr == i_rd)  && (i_rd  != '0);

    assign hazard = ((i_rs1 != '0) && pend_q[i_rs1] && !hit_rs1)
                 || ((i_rs2 != '0) && pend_q[i_rs2] && !hit_rs2)
                 || (i_rd_we && (i_rd != '0) && pend_q[i_rd] && !hit_rd);

    assign o_ready = rst && !hazard && ((state_q == EMPTY) || i_ready);
    assign accept  = i_valid && o_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= EMPTY;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (accept)                            state_d = FULL;
        else if ((state_q == FULL) && i_ready) state_d = EMPTY;
    end

    always_comb begin
        o_valid = (state_q == FULL);
    end

    always_comb begin
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        rd_we_d = rd_we_q;
        if (accept) begin
            rs1_d   = (i_rs1 == '0) ? '0 : (hit_rs1 ? i_wb_data : i_rf_rd_data_1);
            rs2_d   = (i_rs2 == '0) ? '0 : (hit_rs2 ? i_wb_data : i_rf_rd_data_2);
            rd_d    = i_rd;
            rd_we_d = i_rd_we;
        end
    end

    // Clear first so a same-cycle set on the same register wins.
    always_comb begin
        pend_d = pend_q;
        if (i_wb_we && (i_wb_addr != '0))
            pend_d[i_wb_addr] = 1'b0;
        if (accept && i_rd_we && (i_rd != '0))
            pend_d[i_rd] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q  <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            rd_we_q <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            rd_we_q <= rd_we_d;
        end
    end

    assign o_rs1_data = rs1_q;
    assign o_rs2_data = rs2_q;
    assign o_rd       = rd_q;
    assign o_rd_we    = rd_we_q;
endmodule
